csr_file_mirq: RTL
==================

// Module: csr_file_mirq
// PURPOSE
//  Machine-mode CSR file for the pipelined core with NUM_IRQ prioritised external interrupt lines.
//  Handles CSR read/write/set/clear, mstatus MIE/MPIE save-restore on trap entry and mret,
//  and direct or vectored trap targets. Sits beside the execute stage; drives the PC redirect (epc/epctaken).
// PARAMETERS
//  NUM_IRQ      4         external interrupt lines, 1..16; line i maps to mip/mie bit 16+i, cause 16+i
//  MTVEC_RESET  32'h0     mtvec value after reset
//  HART_ID      32'h0     value read from mhartid (0xF14)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous reset, active-low
//  addr       in   12       CSR address
//  wdata      in   32       CSR operand
//  csr_op     in   2        00 write, 01 set (|=), 10 clear (&=~), 11 reserved (no write)
//  wr_en      in   1        apply csr_op to addr this cycle
//  rd_en      in   1        read addr this cycle
//  pc         in   32       PC of the instruction in the CSR stage
//  irq        in   NUM_IRQ  level interrupt requests
//  is_mret    in   1        mret in CSR stage
//  instr_ret  in   1        one instruction retired this cycle
//  rdata      out  32       read data (combinational)
//  illegal    out  1        rd_en|wr_en to unimplemented address, or write to read-only CSR
//  epc        out  32       redirect target
//  epctaken   out  1        redirect valid
// BEHAVIOUR
//  Reset (reset=0, async): mstatus, mie, mip, mepc, mcause, counters = 0; mtvec = MTVEC_RESET. rdata/epc/epctaken/illegal = 0.
//  Implemented: mstatus 0x300 (bits 3 MIE, 7 MPIE writable, rest read 0), mie 0x304, mtvec 0x305, mepc 0x341 ([1:0] read 0),
//   mcause 0x342, mip 0x344, mhartid 0xF14 (read-only). mie/mip: only bits 16+i for i<NUM_IRQ exist, others read 0.
//  mtvec: [0] MODE (1 vectored, 0 direct), [1] reads 0; BASE = {mtvec[31:2],2'b00}.
//  rdata = selected CSR when rd_en, else 0; unknown address -> 0 and illegal=1.
//  mip[16+i] set every cycle irq[i]=1 (sticky); cleared only by CSR write/clear; set wins over clear same cycle.
//  pend = mip & mie; trap_req = mstatus.MIE & |pend. Priority: lowest i wins -> cause c = 16+i.
//  Redirect (combinational, same cycle): is_mret -> epctaken=1, epc=mepc. Else trap_req -> epctaken=1,
//   epc = BASE (direct) or BASE + 4*c (vectored). Else epctaken=0, epc=pc. mret beats trap same cycle.
//  Trap entry (registered at that edge): mepc<=pc, mcause<={1'b1,26'b0,c[4:0]}, MPIE<=MIE, MIE<=0.
//   MIE cleared -> trap_req deasserts next cycle; one-cycle epctaken per trap.
//  mret (registered): MIE<=MPIE, MPIE<=1; trap can then fire the cycle after.
//  Hardware trap/mret update beats a same-cycle software write to mstatus/mepc/mcause; other CSRs take the write.
//  Writes to mhartid: ignored, illegal=1. csr_op=11: no state change.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: 64-bit mcycle (0xB00 lo, 0xB80 hi), minstret (0xB02 lo, 0xB82 hi).
//   mcycle +1 every cycle, minstret +1 when instr_ret; both wrap 2^64-1 -> 0; carry lo->hi same cycle.
//   Software write to a half replaces that half and suppresses that counter's increment that cycle.
//  Undefined: addresses absent, read 0, illegal=1; no counter flops.
// TESTING
//  Reset mid-run: reset=0 async while mie=FFFF_0000 -> all CSRs 0, mtvec=MTVEC_RESET, epctaken=0 without a clk edge.
//  mtvec=0x100, mie[17]=1, MIE=1, irq=4'b0010, pc=0x40 -> epctaken=1, epc=0x100; next: mepc=0x40, mcause=0x8000_0011, MIE=0, MPIE=1.
//  Vectored: mtvec=0x101, irq=4'b0110 both enabled -> epc=0x100+4*17=0x144 (line 1 beats 2).
//  mret same cycle as pending trap -> epc=mepc; next cycle MIE=1, then trap to 0x144.
//  Set/clear: csr_op=01 mie wdata=0x0001_0000 then csr_op=10 wdata=0x0001_0000 -> mie=0x0001_0000 then 0; write 0x300 -> illegal=0.
//  CSR_COUNTERS_EN: write 0xB00=FFFF_FFFF, 0xB80=0 -> next cycle mcycle hi=1, lo=0; unset -> read 0xB00 gives 0, illegal=1.

Source files
------------

// File: rtl/csr_file_mirq_if.sv
// CSR access bus between the execute stage and the machine-mode CSR file.
// The core drives address/operand/op/enables; the CSR file returns read data and the illegal flag.
interface csr_file_mirq_if;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [1:0]  csr_op;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] rdata;
   logic        illegal;

   modport master (
      output addr, wdata, csr_op, wr_en, rd_en,
      input  rdata, illegal
   );

   modport slave (
      input  addr, wdata, csr_op, wr_en, rd_en,
      output rdata, illegal
   );
endinterface

// File: rtl/csr_file_mirq.sv
// Machine-mode CSR file with NUM_IRQ prioritised external interrupts, trap entry/mret and PC redirect.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file_mirq #(
   parameter int unsigned NUM_IRQ     = 4,
   parameter logic [31:0] MTVEC_RESET = 32'h0,
   parameter logic [31:0] HART_ID     = 32'h0
) (
   input  logic               clk,
   input  logic               reset,
   csr_file_mirq_if.slave     bus,
   input  logic [31:0]        pc,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               is_mret,
   input  logic               instr_ret,
   output logic [31:0]        epc,
   output logic               epctaken
);

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_SET   = 2'b01,
      OP_CLEAR = 2'b10,
      OP_NONE  = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;

   // Interrupt line i lives at mie/mip bit 16+i; every other bit is hard-wired to zero.
   localparam logic [31:0] IRQ_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;

   logic        mstatus_mie;
   logic        mstatus_mpie;
   logic [31:0] mie_q;
   logic [31:0] mip_q;
   logic [29:0] mtvec_base;
   logic        mtvec_mode;
   logic [29:0] mepc_q;
   logic [31:0] mcause_q;

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q;
   logic [63:0] minstret_q;
`else
   logic        unused_instr_ret;
   assign unused_instr_ret = instr_ret;
`endif

   logic [31:0] irq_vec;
   logic [31:0] pend;
   logic [31:0] csr_cur;
   logic [31:0] new_val;
   logic [4:0]  cause;
   logic        hit;
   logic        wr_active;
   logic        trap_req;
   logic        take_trap;
   logic [31:0] trap_target;

   assign irq_vec   = 32'(irq) << 16;
   assign pend      = mip_q & mie_q;
   assign trap_req  = mstatus_mie & (|pend);
   assign take_trap = trap_req & ~is_mret;
   assign wr_active = bus.wr_en & (csr_op_e'(bus.csr_op) != OP_NONE);

   // Lowest-numbered pending line wins; scanning downward lets the last hit be the lowest.
   always_comb begin
      cause = 5'd0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (pend[16+i]) cause = 5'(16 + i);
      end
   end

   assign trap_target = {mtvec_base, 2'b00} + (mtvec_mode ? {25'b0, cause, 2'b00} : 32'h0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      csr_cur = '0;
      hit     = 1'b1;
      case (bus.addr)
         ADDR_MSTATUS:   csr_cur = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
         ADDR_MIE:       csr_cur = mie_q;
         ADDR_MTVEC:     csr_cur = {mtvec_base, 1'b0, mtvec_mode};
         ADDR_MEPC:      csr_cur = {mepc_q, 2'b00};
         ADDR_MCAUSE:    csr_cur = mcause_q;
         ADDR_MIP:       csr_cur = mip_q;
         ADDR_MHARTID:   csr_cur = HART_ID;
`ifdef CSR_COUNTERS_EN
         ADDR_MCYCLE:    csr_cur = mcycle_q[31:0];
         ADDR_MCYCLEH:   csr_cur = mcycle_q[63:32];
         ADDR_MINSTRET:  csr_cur = minstret_q[31:0];
         ADDR_MINSTRETH: csr_cur = minstret_q[63:32];
`endif
         default:        hit     = 1'b0;
      endcase
   end

   always_comb begin
      case (csr_op_e'(bus.csr_op))
         OP_WRITE: new_val = bus.wdata;
         OP_SET:   new_val = csr_cur | bus.wdata;
         OP_CLEAR: new_val = csr_cur & ~bus.wdata;
         default:  new_val = csr_cur;
      endcase
   end

   assign bus.rdata   = (reset && bus.rd_en) ? csr_cur : 32'h0;
   assign bus.illegal = reset & (bus.rd_en | bus.wr_en)
                        & (~hit | (bus.wr_en & (bus.addr == ADDR_MHARTID)));

   always_comb begin
      epctaken = 1'b0;
      epc      = pc;
      if (!reset) begin
         epc = 32'h0;
      end else if (is_mret) begin
         epctaken = 1'b1;
         epc      = {mepc_q, 2'b00};
      end else if (trap_req) begin
         epctaken = 1'b1;
         epc      = trap_target;
      end
   end

   logic we_mstatus, we_mie, we_mtvec, we_mepc, we_mcause, we_mip;
   assign we_mstatus = wr_active & (bus.addr == ADDR_MSTATUS);
   assign we_mie     = wr_active & (bus.addr == ADDR_MIE);
   assign we_mtvec   = wr_active & (bus.addr == ADDR_MTVEC);
   assign we_mepc    = wr_active & (bus.addr == ADDR_MEPC);
   assign we_mcause  = wr_active & (bus.addr == ADDR_MCAUSE);
   assign we_mip     = wr_active & (bus.addr == ADDR_MIP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_q        <= '0;
         mip_q        <= '0;
         mtvec_base   <= MTVEC_RESET[31:2];
         mtvec_mode   <= MTVEC_RESET[0];
         mepc_q       <= '0;
         mcause_q     <= '0;
      end else begin
         if (we_mstatus) begin
            mstatus_mie  <= new_val[3];
            mstatus_mpie <= new_val[7];
         end
         if (we_mie) mie_q <= new_val & IRQ_MASK;
         if (we_mtvec) begin
            mtvec_base <= new_val[31:2];
            mtvec_mode <= new_val[0];
         end
         if (we_mepc)   mepc_q   <= new_val[31:2];
         if (we_mcause) mcause_q <= new_val;
         // Incoming request bits are ORed after the software value, so set beats clear.
         mip_q <= ((we_mip ? new_val : mip_q) | irq_vec) & IRQ_MASK;

         // NOTE: non-blocking assignments; the later one in this block wins, so the
         // hardware trap/mret update below overrides a same-cycle software write.
         if (take_trap) begin
            mepc_q       <= pc[31:2];
            mcause_q     <= {1'b1, 26'b0, cause};
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (is_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end
      end
   end

`ifdef CSR_COUNTERS_EN
   // A software write to either half replaces that half and skips the increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (wr_active && bus.addr == ADDR_MCYCLE)        mcycle_q[31:0]  <= new_val;
         else if (wr_active && bus.addr == ADDR_MCYCLEH)  mcycle_q[63:32] <= new_val;
         else                                             mcycle_q        <= mcycle_q + 64'd1;

         if (wr_active && bus.addr == ADDR_MINSTRET)       minstret_q[31:0]  <= new_val;
         else if (wr_active && bus.addr == ADDR_MINSTRETH) minstret_q[63:32] <= new_val;
         else if (instr_ret)                               minstret_q        <= minstret_q + 64'd1;
      end
   end
`endif

endmodule
